alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution stage directly downstream of the ALU control decoder: consumes the 4-bit ALU control code plus two operands and produces a registered result, flags and HI/LO.
- Single-cycle ops (add/sub/logic/shift) complete at the accepting edge.
- mult/div run as iterative multi-cycle operations under a start/busy/done handshake, so the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted on an edge where start=1 and busy=0
- ALU_control  input  4  operation code (encoding below)
- A  input  WIDTH  operand rs
- B  input  WIDTH  operand rt
- shamt  input  5  shift amount for sll/srl
- result  output  WIDTH  registered result
- zero  output  1  registered (result==0)
- overflow  output  1  registered signed overflow, add/sub only
- HI  output  WIDTH  mult high word / div remainder
- LO  output  WIDTH  mult low word / div quotient
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse: result, flags (and HI/LO for mult/div) valid

Behaviour:
- Reset (sync, active-high): result, HI, LO = 0; zero = 1; overflow, busy, done = 0; state = IDLE. Reset aborts any in-flight mult/div and discards partial results.
- Encoding:
  - 0000 add: A+B. 0001 sub: A-B.
  - 0010 mult: signed A*B. 0011 div: signed A/B.
  - 0100 sll: B<<shamt. 0101 srl: B>>shamt, logical.
  - 1000 and. 1001 or. 1010 xor. 1011 nor.
  - Any other code: result=0, done pulses.
- Accept: on an edge with start=1 and busy=0, operation and operands are sampled. Inputs are don't-care afterwards. start while busy=1 is ignored; there is no queueing.
- Single-cycle ops, at the accepting edge:
  - result, zero and overflow are written; done<=1 for exactly one cycle; busy stays 0; HI/LO are unchanged.
  - overflow = operand signs equal (for sub: A sign differs from B sign) and result sign differs from A sign.
  - overflow<=0 for every non-add/sub op.
  - Back-to-back single-cycle starts complete every cycle, with done held high continuously.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: on accepting mult/div, latch |A|, |B| and the sign information; counter<=0; busy<=1; done<=0; go to MUL or DIV.
  - MUL: one shift-add iteration per edge on a 2*WIDTH accumulator. After WIDTH iterations go to FIX.
  - DIV: one restoring-division iteration per edge. After WIDTH iterations go to FIX.
  - FIX: apply sign correction, write HI/LO, result<=LO, zero<=(LO==0), overflow<=0, done<=1, busy<=0, then go to IDLE.
- Mult/div latency: the accepting edge is E0; iterations run on E1..EWIDTH; FIX is E(WIDTH+1). done is high in the cycle after E33 for WIDTH=32. busy is high from after E0 until E(WIDTH+1).
- A new start is legal in the same cycle done is high.
- Sign rules:
  - mult: negate the 2*WIDTH product if sign(A)!=sign(B).
  - div: the quotient takes sign(A)^sign(B); the remainder takes sign(A), so truncation is toward zero.
  - Most negative / -1: LO = most negative value, HI = 0; no trap.
- Divide by zero (B=0, checked at accept): the iteration still runs the full latency. Result: LO = all ones, HI = A, done pulses normally.
- Shift amounts use only shamt[4:0]; shamt=0 passes B unchanged.
- done is never asserted without a preceding accept. Nothing is written to HI/LO except by the FIX state.

Test Plan:
- Reset, then add A=7, B=5 → next cycle result=12, zero=0, done=1 for one cycle, busy=0. Then sub A=5, B=5 → result=0, zero=1.
- add A=0x7FFFFFFF, B=1 → result=0x80000000, overflow=1. sub A=0x80000000, B=1 → result=0x7FFFFFFF, overflow=1. nor A=0, B=0 → 0xFFFFFFFF, overflow=0.
- sll B=0x00000001, shamt=31 → 0x80000000. srl B=0x80000000, shamt=31 → 0x00000001. shamt=0 → B unchanged.
- mult A=-3 (0xFFFFFFFD), B=7 → busy high for 33 cycles, done in cycle 34. Required: HI=0xFFFFFFFF, LO=0xFFFFFFEB, result=LO. A start(add) issued mid-operation is ignored and HI/LO are not corrupted.
- div A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). div A=9, B=0 → LO=0xFFFFFFFF, HI=9, same latency.
- Assert reset at cycle 10 of a mult → next cycle busy=0, done=0, HI=LO=0, result=0. A subsequent add A=1, B=1 completes normally with result=2.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution stage behind the ALU control decoder.
// Single-cycle ops (add/sub/logic/shift) complete at the accepting edge.
// mult/div run iteratively: shift-add multiply and restoring divide on
// operand magnitudes, followed by a FIX cycle that applies the signs and
// writes HI/LO.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MULT = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state_reg;
  logic [2*WIDTH-1:0]   acc_reg;     // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     mcand_reg;   // |B|: multiplicand or divisor
  logic [CNT_W-1:0]     cnt_reg;
  logic                 neg_reg;     // sign(A) ^ sign(B)
  logic                 a_sign_reg;  // remainder sign for div
  logic                 div0_reg;    // divisor was zero at accept
  logic                 is_div_reg;
  logic [WIDTH-1:0]     a_save_reg;  // raw A, returned in HI on divide by zero
  logic [WIDTH-1:0]     result_reg;
  logic                 zero_reg;
  logic                 overflow_reg;
  logic [WIDTH-1:0]     hi_reg;
  logic [WIDTH-1:0]     lo_reg;
  logic                 busy_reg;
  logic                 done_reg;

  assign result   = result_reg;
  assign zero     = zero_reg;
  assign overflow = overflow_reg;
  assign HI       = hi_reg;
  assign LO       = lo_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  // Single-cycle datapath and operand magnitudes for mult/div setup
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sc_result;
  logic             sc_ovf;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  // Result and overflow for the single-cycle operations
  always_comb begin
    sum       = A + B;
    diff      = A - B;
    sc_result = '0;
    sc_ovf    = 1'b0;
    a_abs     = A[WIDTH-1] ? -A : A;
    b_abs     = B[WIDTH-1] ? -B : B;
    case (ALU_control)
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  sc_result = B << shamt;
      OP_SRL:  sc_result = B >> shamt;
      OP_AND:  sc_result = A & B;
      OP_OR:   sc_result = A | B;
      OP_XOR:  sc_result = A ^ B;
      OP_NOR:  sc_result = ~(A | B);
      default: sc_result = '0;
    endcase
  end

  // One iteration step for each iterative unit, plus the sign fix-up
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH-1:0]     quo_mag;
  logic [WIDTH-1:0]     rem_mag;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  // Shift-add / restoring-divide step and final sign correction
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mcand_reg};
    mul_next  = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                           : {1'b0, acc_reg[2*WIDTH-1:1]};
    // Borrow out of the (WIDTH+1)-bit subtract means the trial failed.
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    div_next  = !div_diff[WIDTH] ? {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1}
                                 : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    mul_prod  = neg_reg ? -acc_reg : acc_reg;
    quo_mag   = acc_reg[WIDTH-1:0];
    rem_mag   = acc_reg[2*WIDTH-1:WIDTH];
    if (!is_div_reg) begin
      fix_hi = mul_prod[2*WIDTH-1:WIDTH];
      fix_lo = mul_prod[WIDTH-1:0];
    end else if (div0_reg) begin
      fix_hi = a_save_reg;
      fix_lo = '1;
    end else begin
      fix_hi = a_sign_reg ? -rem_mag : rem_mag;
      fix_lo = neg_reg ? -quo_mag : quo_mag;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      mcand_reg    <= '0;
      cnt_reg      <= '0;
      neg_reg      <= 1'b0;
      a_sign_reg   <= 1'b0;
      div0_reg     <= 1'b0;
      is_div_reg   <= 1'b0;
      a_save_reg   <= '0;
      result_reg   <= '0;
      zero_reg     <= 1'b1;
      overflow_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (ALU_control == OP_MULT || ALU_control == OP_DIV) begin
              acc_reg    <= {{WIDTH{1'b0}}, a_abs};
              mcand_reg  <= b_abs;
              cnt_reg    <= '0;
              neg_reg    <= A[WIDTH-1] ^ B[WIDTH-1];
              a_sign_reg <= A[WIDTH-1];
              div0_reg   <= (B == '0);
              is_div_reg <= (ALU_control == OP_DIV);
              a_save_reg <= A;
              busy_reg   <= 1'b1;
              state_reg  <= (ALU_control == OP_MULT) ? MUL : DIV;
            end else begin
              result_reg   <= sc_result;
              zero_reg     <= (sc_result == '0);
              overflow_reg <= sc_ovf;
              done_reg     <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_reg <= mul_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= FIX;
        end
        DIV: begin
          acc_reg <= div_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= FIX;
        end
        FIX: begin
          hi_reg       <= fix_hi;
          lo_reg       <= fix_lo;
          result_reg   <= fix_lo;
          zero_reg     <= (fix_lo == '0);
          overflow_reg <= 1'b0;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: table-driven single-cycle vectors plus
// hand-written mult/div, mid-operation start and reset-abort sequences.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALU_control;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;

  int pass_count = 0;
  int total_count = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALU_control(ALU_control),
    .A(A), .B(B), .shamt(shamt), .result(result), .zero(zero),
    .overflow(overflow), .HI(HI), .LO(LO), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_count++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_count++;
  endtask

  // Run one mult/div and check latency, HI/LO, result and flags.
  task automatic run_md(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit inject);
    int  n;
    bit  got_done;
    @(negedge clk);
    start = 1'b1; ALU_control = ctrl; A = a; B = b; shamt = 5'd0;
    @(posedge clk); #1;
    check("md_busy_after_accept", {63'd0, busy}, 64'd1);
    n = 1;
    got_done = 0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      @(negedge clk);
      start = inject && (c == 5);
      ALU_control = 4'b0000; A = 32'd1; B = 32'd1;
      @(posedge clk); #1;
      if (done) got_done = 1;
      else if (busy) n++;
    end
    start = 1'b0;
    check("md_done_seen", {63'd0, got_done}, 64'd1);
    check("md_busy_cycles", 64'(n), 64'd33);
    check("md_busy_at_done", {63'd0, busy}, 64'd0);
    check("md_hi", {32'd0, HI}, {32'd0, exp_hi});
    check("md_lo", {32'd0, LO}, {32'd0, exp_lo});
    check("md_result", {32'd0, result}, {32'd0, exp_lo});
    check("md_zero", {63'd0, zero}, {63'd0, exp_lo == 32'd0});
    check("md_overflow", {63'd0, overflow}, 64'd0);
    $display("md ctrl=%b A=%h B=%h -> HI=%h LO=%h busy_cycles=%0d", ctrl, a, b, HI, LO, n);
    @(posedge clk); #1;
    check("md_done_pulse", {63'd0, done}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 32'd7,        32'd5,        5'd0,  32'd12,       1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 32'd5,        32'd5,        5'd0,  32'd0,        1'b1, 1'b0};
    vecs[2]  = '{4'b0000, 32'h7FFFFFFF, 32'd1,        5'd0,  32'h80000000, 1'b0, 1'b1};
    vecs[3]  = '{4'b0001, 32'h80000000, 32'd1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4]  = '{4'b1011, 32'd0,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[5]  = '{4'b0100, 32'd0,        32'd1,        5'd31, 32'h80000000, 1'b0, 1'b0};
    vecs[6]  = '{4'b0101, 32'd0,        32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100, 32'd0,        32'h12345678, 5'd0,  32'h12345678, 1'b0, 1'b0};
    vecs[8]  = '{4'b0101, 32'd0,        32'h9ABCDEF0, 5'd0,  32'h9ABCDEF0, 1'b0, 1'b0};
    vecs[9]  = '{4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0};
    vecs[10] = '{4'b1001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0};
    vecs[11] = '{4'b1010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0, 1'b0};
    vecs[12] = '{4'b0111, 32'd5,        32'd5,        5'd0,  32'd0,        1'b1, 1'b0};
    vecs[13] = '{4'b0001, 32'd3,        32'd5,        5'd0,  32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[14] = '{4'b0101, 32'd0,        32'hF0000000, 5'd4,  32'h0F000000, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; ALU_control = 4'd0; A = '0; B = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back single-cycle vectors: done must stay high each cycle.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = 1'b1; ALU_control = vecs[i].ctrl; A = vecs[i].a; B = vecs[i].b; shamt = vecs[i].sh;
      @(posedge clk); #1;
      check("vec_result", {32'd0, result}, {32'd0, vecs[i].res});
      check("vec_zero", {63'd0, zero}, {63'd0, vecs[i].z});
      check("vec_overflow", {63'd0, overflow}, {63'd0, vecs[i].ov});
      check("vec_done", {63'd0, done}, 64'd1);
      check("vec_busy", {63'd0, busy}, 64'd0);
      $display("vec %0d ctrl=%b A=%h B=%h sh=%0d -> result=%h zero=%b ovf=%b",
               i, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh, result, zero, overflow);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("single_done_pulse", {63'd0, done}, 64'd0);
    check("single_hilo_untouched", {HI, LO}, 64'd0);

    // Multi-cycle operations; the first also fires an ignored add mid-run.
    run_md(4'b0010, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
    run_md(4'b0010, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);
    run_md(4'b0011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_md(4'b0011, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_md(4'b0011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_md(4'b0011, 32'd9,        32'd0,        32'h00000009, 32'hFFFFFFFF, 1'b0);

    // A single-cycle op must leave HI/LO alone.
    @(negedge clk);
    start = 1'b1; ALU_control = 4'b0000; A = 32'd2; B = 32'd3;
    @(posedge clk); #1;
    check("add_after_div_result", {32'd0, result}, 64'd5);
    check("add_after_div_hilo", {HI, LO}, {32'd9, 32'hFFFFFFFF});
    $display("add A=2 B=3 -> result=%h HI=%h LO=%h", result, HI, LO);
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of a mult aborts it.
    @(negedge clk);
    start = 1'b1; ALU_control = 4'b0010; A = 32'd6; B = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    $display("reset mid-mult -> busy=%b done=%b HI=%h LO=%h", busy, done, HI, LO);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) check("abort_spurious_done", {63'd0, done}, 64'd0);
    end
    @(negedge clk);
    start = 1'b1; ALU_control = 4'b0000; A = 32'd1; B = 32'd1;
    @(posedge clk); #1;
    check("post_abort_add", {32'd0, result}, 64'd2);
    check("post_abort_done", {63'd0, done}, 64'd1);
    $display("add A=1 B=1 -> result=%h done=%b", result, done);
    @(negedge clk);
    start = 1'b0;

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
